// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine. Processes one 128-bit state block, COLS_PER_CYCLE columns per clock.
// Latency: out_valid rises N = 4/COLS_PER_CYCLE edges after the input-transfer edge.
// Backpressure: one block in flight. in_ready is low while RUN, and in DONE it follows out_ready.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   in_valid/in_ready      input handshake; in_data (128b) and in_inv are captured on transfer
//   out_valid/out_ready    output handshake; out_data (128b) holds the last finished block
//   busy                   high while the engine is in RUN
// Configuration:
//   COLS_PER_CYCLE         1, 2 or 4 columns per clock
//   MIX_COLUMNS_INV_EN     when defined, the inverse datapath is compiled in and in_inv selects the mode.
//                          When it is undefined, in_inv is ignored and every block uses the forward transform.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // The counter wraps mod 4. With 4 columns per cycle, STEP is 0 and the single RUN cycle is also the last one.
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  state_t       state, state_nxt;
  logic [1:0]   cnt;
  logic [127:0] work, work_upd;
  logic         in_xfer, out_xfer, last_step;
  logic [1:0]   col_idx;
  logic [31:0]  col_in;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward column. The row sum is shared: each output is a_i ^ (sum of all four bytes) ^ 2*(a_i ^ a_{i+1}).
  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, t;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    t  = a0 ^ a1 ^ a2 ^ a3;
    fwd_col = {a0 ^ t ^ xtime(a0 ^ a1),
               a1 ^ t ^ xtime(a1 ^ a2),
               a2 ^ t ^ xtime(a2 ^ a3),
               a3 ^ t ^ xtime(a3 ^ a0)};
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  // Inverse column. The 09/0b/0d/0e multiples are formed from the x2, x4 and x8 xtime chain of each byte.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    inv_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
               m9[0] ^ me[1] ^ mb[2] ^ md[3],
               md[0] ^ m9[1] ^ me[2] ^ mb[3],
               mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  logic mode;

  // The mode is latched with the block, so later changes on in_inv do not affect a block already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= 1'b0;
    end else if (in_xfer) begin
      mode <= in_inv;
    end
  end
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
`endif

  assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign last_step = (state == RUN) && (cnt == LAST_CNT);

  // Replace columns cnt .. cnt+COLS_PER_CYCLE-1 of the working block.
  always_comb begin
    work_upd = work;
    col_idx  = '0;
    col_in   = '0;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      col_idx = cnt + 2'(j);
      col_in  = work[127 - 32*int'(col_idx) -: 32];
`ifdef MIX_COLUMNS_INV_EN
      work_upd[127 - 32*int'(col_idx) -: 32] = mode ? inv_col(col_in) : fwd_col(col_in);
`else
      work_upd[127 - 32*int'(col_idx) -: 32] = fwd_col(col_in);
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_xfer) state_nxt = RUN;
      RUN:  if (cnt == LAST_CNT) state_nxt = DONE;
      DONE: if (out_xfer) state_nxt = in_xfer ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      work      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy      <= (state_nxt == RUN);
      out_valid <= (state_nxt == DONE);
      if (in_xfer) begin
        work <= in_data;
        cnt  <= '0;
      end else if (state == RUN) begin
        work <= work_upd;
        cnt  <= cnt + STEP;
      end
      // The finished block is published here and then held until the next block completes.
      if (last_step) begin
        out_data <= work_upd;
      end
    end
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine. Two instances are driven: COLS_PER_CYCLE=1 (index 0) and COLS_PER_CYCLE=4 (index 1).
// Drivers push expected blocks into per-instance queues, and a monitor per instance checks latency, hold and data.
module tb_mix_columns_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic         in_inv    [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic         busy      [2];
  logic [127:0] in_data   [2];
  logic [127:0] out_data  [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [127:0] d;
    int           acc;
  } exp_t;

  exp_t q [2][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Reference model: generic shift-and-add GF(2^8) multiply with a rotated coefficient row.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] coef(input logic inv, input int k);
    case ({inv, 2'(k)})
      3'b000: return 8'h02;
      3'b001: return 8'h03;
      3'b010: return 8'h01;
      3'b011: return 8'h01;
      3'b100: return 8'h0e;
      3'b101: return 8'h0b;
      3'b110: return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   acc;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = d[127 - 32*c - 8*i -: 8];
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef(inv, (j - i + 4) % 4), a[j]);
        r[127 - 32*c - 8*i -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_of(input logic [127:0] d, input logic inv);
`ifdef MIX_COLUMNS_INV_EN
    return model(d, inv);
`else
    return model(d, 1'b0 & inv);
`endif
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int C = (g == 0) ? 1 : 4;
    localparam int N = 4 / C;

    mix_columns_engine #(.COLS_PER_CYCLE(C)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_inv    (in_inv[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );

    initial begin
      logic         seen;
      logic [127:0] held;
      exp_t         e;
      seen = 1'b0;
      held = '0;
      forever begin
        @(negedge clk);
        #2;
        if (rst) begin
          seen = 1'b0;
          continue;
        end
        if (out_valid[g]) begin
          if (q[g].size() == 0) begin
            chk($sformatf("spurious_valid%0d", g), 128'(out_valid[g]), 128'd0);
          end else begin
            e = q[g][0];
            if (!seen) begin
              chk($sformatf("latency%0d", g), 128'(cyc - e.acc), 128'(N));
              seen = 1'b1;
              held = out_data[g];
            end else begin
              chk($sformatf("hold%0d", g), out_data[g], held);
            end
            if (out_ready[g]) begin
              chk($sformatf("data%0d", g), out_data[g], e.d);
              void'(q[g].pop_front());
              seen = 1'b0;
            end
          end
        end else if (seen) begin
          chk($sformatf("valid_dropped%0d", g), 128'(out_valid[g]), 128'd1);
          seen = 1'b0;
        end
      end
    end
  end

  task automatic drive(input int g, input logic v, input logic [127:0] d, input logic inv,
                       input logic ordy, input logic [127:0] expd, output logic took);
    @(negedge clk);
    in_valid[1-g]  = 1'b0;
    in_valid[g]    = v;
    in_data[g]     = d;
    in_inv[g]      = inv;
    out_ready[g]   = ordy;
    #1;
    took = v && in_ready[g];
    if (took) q[g].push_back('{expd, cyc + 1});
  endtask

  task automatic send(input int g, input logic [127:0] d, input logic inv, input logic ordy,
                      input logic [127:0] expd);
    logic took;
    took = 1'b0;
    for (int i = 0; i < 200 && !took; i++) drive(g, 1'b1, d, inv, ordy, expd, took);
    if (!took) chk("send_timeout", 128'd0, 128'd1);
  endtask

  task automatic drain(input int g);
    logic took;
    for (int i = 0; i < 300 && q[g].size() != 0; i++) drive(g, 1'b0, '0, 1'b0, 1'b1, '0, took);
    if (q[g].size() != 0) chk($sformatf("drain_timeout%0d", g), 128'(q[g].size()), 128'd0);
  endtask

  localparam logic [127:0] V_A   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] V_B   = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] V_C   = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] V_D   = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

  initial begin
    logic         took;
    logic [127:0] d, inv_exp_b, inv_exp_d;
    logic         v, r, m;
    int           sent;

`ifdef MIX_COLUMNS_INV_EN
    inv_exp_b = V_A;
    inv_exp_d = V_C;
`else
    inv_exp_b = model(V_B, 1'b0);
    inv_exp_d = V_C ^ V_C ^ model(V_D, 1'b0);
`endif

    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      in_valid[g]  = 1'b0;
      in_inv[g]    = 1'b0;
      in_data[g]   = '0;
      out_ready[g] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_in_ready%0d", g), 128'(in_ready[g]), 128'd0);
      chk($sformatf("rst_out_valid%0d", g), 128'(out_valid[g]), 128'd0);
      chk($sformatf("rst_busy%0d", g), 128'(busy[g]), 128'd0);
      chk($sformatf("rst_out_data%0d", g), out_data[g], 128'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) chk($sformatf("post_rst_in_ready%0d", g), 128'(in_ready[g]), 128'd1);

    // Known-answer blocks on both instances. The busy checks are taken in the first RUN cycle.
    send(0, V_A, 1'b0, 1'b1, V_B);
    drive(0, 1'b0, '0, 1'b1, 1'b1, '0, took);
    chk("busy_run0", 128'(busy[0]), 128'd1);
    chk("in_ready_run0", 128'(in_ready[0]), 128'd0);
    drain(0);
    send(0, V_B, 1'b1, 1'b1, inv_exp_b);
    drive(0, 1'b0, '0, 1'b0, 1'b1, '0, took);
    drain(0);
    send(1, V_C, 1'b0, 1'b1, V_D);
    drive(1, 1'b0, '0, 1'b1, 1'b1, '0, took);
    chk("busy_run1", 128'(busy[1]), 128'd1);
    drain(1);
    send(1, V_D, 1'b1, 1'b1, inv_exp_d);
    drain(1);

    // Hold the output for 10 cycles, then transfer the output and the next input on the same edge.
    send(0, V_A, 1'b0, 1'b0, V_B);
    repeat (4) drive(0, 1'b0, '0, 1'b0, 1'b0, '0, took);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'b0, '0, 1'b0, 1'b0, '0, took);
      chk("stall_in_ready", 128'(in_ready[0]), 128'd0);
      chk("stall_out_valid", 128'(out_valid[0]), 128'd1);
    end
    drive(0, 1'b1, V_C, 1'b0, 1'b1, V_D, took);
    chk("overlap_accept", 128'(took), 128'd1);
    drive(0, 1'b0, '0, 1'b0, 1'b1, '0, took);
    chk("overlap_busy", 128'(busy[0]), 128'd1);
    drain(0);

    // Reset during the second RUN cycle discards the block.
    send(0, V_A, 1'b0, 1'b1, V_B);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    q[0].delete();
    #1;
    chk("mid_rst_in_ready", 128'(in_ready[0]), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out_data", out_data[0], 128'd0);
    chk("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("mid_rst_busy", 128'(busy[0]), 128'd0);
    @(negedge clk);
    chk("mid_rst_ready_after", 128'(in_ready[0]), 128'd1);
    repeat (6) drive(0, 1'b0, '0, 1'b0, 1'b1, '0, took);

    // Streaming with random valid/ready and random mode on each instance.
    for (int g = 0; g < 2; g++) begin
      sent = 0;
      for (int i = 0; i < 3000 && sent < 50; i++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        m = 1'($urandom_range(0, 1));
        v = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
        drive(g, v, d, m, r, exp_of(d, m), took);
        if (took) sent++;
      end
      chk($sformatf("stream_sent%0d", g), 128'(sent), 128'd50);
      drain(g);
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mix_columns_engine.md
MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1: AES columns processed per clock; legal values 1, 2, 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  in_data/in_inv valid.
REQ-005 in_ready  output  1  engine can accept a block this cycle.
REQ-006 in_data  input  128  state block; byte k at [127-8k -: 8], column c = bytes 4c..4c+3.
REQ-007 in_inv  input  1  0 = forward MixColumns, 1 = InvMixColumns.
REQ-008 out_valid  output  1  out_data holds a finished block.
REQ-009 out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 out_data  output  128  transformed block, same byte ordering as in_data.
REQ-011 busy  output  1  high while state is RUN.

Function
REQ-012 Input transfer occurs on a rising edge where in_valid and in_ready are both high; output transfer occurs where out_valid and out_ready are both high.
REQ-013 FSM states IDLE, RUN, DONE; IDLE->RUN on input transfer; RUN->DONE after N = 4/COLS_PER_CYCLE RUN cycles; DONE->IDLE on output transfer without a simultaneous input transfer; DONE->RUN on simultaneous output and input transfer.
REQ-014 in_ready is high in IDLE, and in DONE when out_ready is high; low in RUN.
REQ-015 in_data and in_inv are registered on input transfer; the mode stays fixed for the whole block regardless of later in_inv changes.
REQ-016 A 2-bit column counter starts at 0 on input transfer and advances by COLS_PER_CYCLE per RUN cycle; each RUN cycle replaces columns cnt..cnt+COLS_PER_CYCLE-1 in the working register.
REQ-017 Forward column transform: r0=2a0^3a1^a2^a3, r1=a0^2a1^3a2^a3, r2=a0^a1^2a2^3a3, r3=3a0^a1^a2^2a3 over GF(2^8), polynomial 0x11B.
REQ-018 xtime(b) = (b<<1) truncated to 8 bits, XOR 0x1B when b[7]=1; multiply-by-3 = xtime(b)^b; addition = bitwise XOR.
REQ-019 Inverse column transform uses coefficient rows {0e,0b,0d,09} rotated as in REQ-017, built from chained xtime.
REQ-020 out_valid rises exactly N clock edges after the input-transfer edge; out_data equals the fully transformed block and stays stable while out_valid is high and out_ready is low.
REQ-021 out_valid falls on an output transfer unless a new block completes in the same edge (not possible for N>=1; out_valid is low during RUN).
REQ-022 out_data retains the last block after transfer until the next block completes.
REQ-023 in_valid is ignored while in_ready is low; no block is dropped or duplicated under any out_ready pattern.

Reset
REQ-024 While rst is high at a rising edge: state<=IDLE, counter<=0, out_valid<=0, busy<=0, out_data<=128'h0, working register<=0.
REQ-025 rst asserted mid-RUN or in DONE discards the block in progress; no out_valid is produced for it.
REQ-026 in_ready is low during the cycle rst is sampled high; it goes high in the first cycle after rst deasserts.

Configuration
REQ-027 Macro MIX_COLUMNS_INV_EN defined: inverse datapath compiled in; in_inv selects mode per REQ-007.
REQ-028 Macro MIX_COLUMNS_INV_EN undefined: inverse datapath omitted, in_inv ignored, every block uses the forward transform.

Verification
REQ-029 COLS_PER_CYCLE=1, in_inv=0, in_data=d4bf5d30e0b452aeb84111f11e2798e5 -> out_data=046681e5e0cb199a48f8d37a2806264c, out_valid 4 edges after transfer.
REQ-030 MIX_COLUMNS_INV_EN defined, in_inv=1, in_data=046681e5e0cb199a48f8d37a2806264c -> out_data=d4bf5d30e0b452aeb84111f11e2798e5; repeat with macro undefined -> forward result of that input.
REQ-031 COLS_PER_CYCLE=4, column pairs db135345 / f20a225c / 01010101 / c6c6c6c6 -> 8e4da1bc / 9fdc589d / 01010101 / c6c6c6c6, out_valid 1 edge after transfer.
REQ-032 out_ready held low 10 cycles after completion -> out_data stable, in_ready low; raising out_ready with in_valid high -> output and input transfer on same edge, FSM to RUN.
REQ-033 rst pulsed for one cycle in the 2nd RUN cycle (COLS_PER_CYCLE=1) -> out_valid never rises for that block, out_data=0, in_ready high the next cycle.
REQ-034 Streaming 100 random blocks with random in_valid/out_ready, both modes -> every output matches a software model in order, no loss or duplication.
